// File: rtl/motor_drv_pkg.sv
// motor_drv_pkg: shared state encoding, direction codes and helpers for the motor bridge driver
// Contents: state_t (OFF/RAMP/RUN/DEAD), DIR_A/DIR_B/DIR_STOP, is_run() run-code check.
package motor_drv_pkg;
  typedef enum logic [1:0] {ST_OFF, ST_RAMP, ST_RUN, ST_DEAD} state_t;
  localparam logic [1:0] DIR_A = 2'b10;
  localparam logic [1:0] DIR_B = 2'b01;
  localparam logic [1:0] DIR_STOP = 2'b00;
  function automatic logic is_run(logic [1:0] d);
    return d == DIR_A || d == DIR_B;
  endfunction
endpackage

// File: rtl/motor_bridge_driver_if.sv
// motor_bridge_driver_if: command and H-bridge signal bundle of the motor bridge driver
// Signals: motor_in[3:0]/motor_en[1:0] commands (async), duty_max target duty (sync),
//          bridge_in[3:0] direction pins, bridge_en[1:0] PWM pins, busy[1:0] dead-time flags.
// Modports: master drives commands, slave (the driver) drives bridge pins.
interface motor_bridge_driver_if #(parameter int PWM_BITS = 8);
  logic [3:0] motor_in;
  logic [1:0] motor_en;
  logic [PWM_BITS-1:0] duty_max;
  logic [3:0] bridge_in;
  logic [1:0] bridge_en;
  logic [1:0] busy;
  modport master(output motor_in, motor_en, duty_max, input bridge_in, bridge_en, busy);
  modport slave(input motor_in, motor_en, duty_max, output bridge_in, bridge_en, busy);
endinterface

// File: rtl/motor_drv_channel.sv
// motor_drv_channel: one H-bridge channel FSM with duty register, ramp timer and dead-time counter
// Ports: clk, rst_n (async active-low), i_dir/i_en synchronized command, i_duty_max target duty,
//        o_bridge direction pair, o_duty current duty, o_busy high during dead-time.
// Macro MOTOR_DRV_RAMP_EN builds the RAMP state and ramp timer; otherwise duty jumps to duty_max.
module motor_drv_channel
  import motor_drv_pkg::*;
#(
  parameter int PWM_BITS = 8,
  parameter int DEAD_CYCLES = 1000,
  parameter int RAMP_STEP = 4,
  parameter int RAMP_DIV = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          i_dir,
  input  logic                i_en,
  input  logic [PWM_BITS-1:0] i_duty_max,
  output logic [1:0]          o_bridge,
  output logic [PWM_BITS-1:0] o_duty,
  output logic                o_busy
);
  localparam int DW = $clog2(DEAD_CYCLES + 1);
  state_t r_state, w_state;
  logic [1:0] r_bridge, w_bridge;
  logic [PWM_BITS-1:0] r_duty, w_duty;
  logic [DW-1:0] r_dead, w_dead;
  logic w_leave;
  if (DEAD_CYCLES < 1 || RAMP_STEP < 1 || RAMP_DIV < 1) begin : g_cfg_err
    $error("motor_drv_channel: DEAD_CYCLES, RAMP_STEP and RAMP_DIV must be positive");
  end
`ifdef MOTOR_DRV_RAMP_EN
  localparam int TW = $clog2(RAMP_DIV + 1);
  logic [TW-1:0] r_tmr, w_tmr;
  logic w_tick;
  logic [PWM_BITS:0] w_sum;
  logic [PWM_BITS-1:0] w_step;
  assign w_tick = r_tmr == TW'(RAMP_DIV - 1);
  // one extra bit so the increment cannot wrap before saturation
  assign w_sum = {1'b0, r_duty} + (PWM_BITS + 1)'(RAMP_STEP);
  assign w_step = !w_tick ? r_duty : (w_sum >= {1'b0, i_duty_max}) ? i_duty_max : w_sum[PWM_BITS-1:0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_tmr <= '0;
    else r_tmr <= w_tmr;
`endif
  // the latched direction is the bridge pair itself, so any mismatch covers stop codes too
  assign w_leave = !i_en || i_dir != r_bridge;
  always_comb begin
    w_state = r_state;
    w_bridge = r_bridge;
    w_duty = r_duty;
    w_dead = r_dead;
`ifdef MOTOR_DRV_RAMP_EN
    w_tmr = r_tmr;
`endif
    if (r_state == ST_DEAD) begin
      w_state = r_dead == '0 ? ST_OFF : ST_DEAD;
      w_dead = r_dead - 1'b1;
    end else if (r_state == ST_OFF) begin
      if (i_en && is_run(i_dir)) begin
        w_bridge = i_dir;
`ifdef MOTOR_DRV_RAMP_EN
        w_duty = '0;
        w_tmr = '0;
        w_state = i_duty_max == '0 ? ST_RUN : ST_RAMP;
`else
        w_duty = i_duty_max;
        w_state = ST_RUN;
`endif
      end
    end else if (w_leave) begin
      w_state = ST_DEAD;
      w_bridge = DIR_STOP;
      w_duty = '0;
      w_dead = DW'(DEAD_CYCLES - 1);
    end else if (r_state == ST_RUN) begin
`ifdef MOTOR_DRV_RAMP_EN
      if (i_duty_max > r_duty) begin
        w_state = ST_RAMP;
        w_tmr = '0;
      end else w_duty = i_duty_max;
`else
      w_duty = i_duty_max;
`endif
    end else begin
`ifdef MOTOR_DRV_RAMP_EN
      w_tmr = w_tick ? '0 : r_tmr + 1'b1;
      w_duty = w_step >= i_duty_max ? i_duty_max : w_step;
      w_state = w_step >= i_duty_max ? ST_RUN : ST_RAMP;
`else
      w_state = ST_OFF;
`endif
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= ST_OFF;
      r_bridge <= DIR_STOP;
      r_duty <= '0;
      r_dead <= '0;
    end else begin
      r_state <= w_state;
      r_bridge <= w_bridge;
      r_duty <= w_duty;
      r_dead <= w_dead;
    end
  assign o_bridge = r_bridge;
  assign o_duty = r_duty;
  assign o_busy = r_state == ST_DEAD;
endmodule

// File: rtl/motor_bridge_driver.sv
// motor_bridge_driver: turns rover motor commands into dead-timed, ramped H-bridge drive for two motors
// Ports: clk, rst_n (async active-low), bus (motor_bridge_driver_if.slave): motor_in/motor_en
//        commands in, duty_max target duty in, bridge_in/bridge_en/busy out.
// Macro MOTOR_DRV_RAMP_EN enables the duty ramp in both channels.
module motor_bridge_driver
  import motor_drv_pkg::*;
#(
  parameter int PWM_BITS = 8,
  parameter int DEAD_CYCLES = 1000,
  parameter int RAMP_STEP = 4,
  parameter int RAMP_DIV = 256
) (
  input logic clk,
  input logic rst_n,
  motor_bridge_driver_if.slave bus
);
  logic [5:0] r_sync1, r_sync2;
  logic [PWM_BITS-1:0] r_pwm;
  logic [1:0] r_en;
  logic [3:0] w_bridge;
  logic [1:0] w_busy;
  logic [PWM_BITS-1:0] w_duty [2];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_pwm <= '0;
      r_en <= '0;
    end else begin
      r_sync1 <= {bus.motor_en, bus.motor_in};
      r_sync2 <= r_sync1;
      r_pwm <= r_pwm + 1'b1;
      r_en <= {r_pwm < w_duty[1], r_pwm < w_duty[0]};
    end
  for (genvar c = 0; c < 2; c++) begin : g_ch
    motor_drv_channel #(
      .PWM_BITS(PWM_BITS), .DEAD_CYCLES(DEAD_CYCLES), .RAMP_STEP(RAMP_STEP), .RAMP_DIV(RAMP_DIV)
    ) u_ch (
      .clk(clk),
      .rst_n(rst_n),
      .i_dir(r_sync2[2*c+1 -: 2]),
      .i_en(r_sync2[4+c]),
      .i_duty_max(bus.duty_max),
      .o_bridge(w_bridge[2*c+1 -: 2]),
      .o_duty(w_duty[c]),
      .o_busy(w_busy[c])
    );
  end
  assign bus.bridge_in = w_bridge;
  // the compare register lags duty by one edge; masking with the pair keeps PWM off the instant the pair stops
  assign bus.bridge_en = r_en & {w_bridge[3:2] != DIR_STOP, w_bridge[1:0] != DIR_STOP};
  assign bus.busy = w_busy;
endmodule

// File: tb/tb_motor_bridge_driver.sv
// tb_motor_bridge_driver: directed scoreboard bench for motor_bridge_driver
module tb_motor_bridge_driver;
  localparam int S_BIN = 0, S_BEN = 1, S_BUSY = 2, S_D0 = 3, S_D1 = 4, S_BEN0 = 5;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  typedef struct {
    int due;
    int sel;
    logic [15:0] exp;
    string tag;
  } exp_t;
  exp_t sb[$];
  motor_bridge_driver_if #(.PWM_BITS(8)) bus ();
  motor_bridge_driver #(.PWM_BITS(8), .DEAD_CYCLES(16), .RAMP_STEP(32), .RAMP_DIV(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [15:0] probe(int sel);
    logic [15:0] v;
    case (sel)
      S_BIN: v = {12'd0, bus.bridge_in};
      S_BEN: v = {14'd0, bus.bridge_en};
      S_BUSY: v = {14'd0, bus.busy};
      S_D0: v = {8'd0, dut.g_ch[0].u_ch.o_duty};
      S_D1: v = {8'd0, dut.g_ch[1].u_ch.o_duty};
      default: v = {15'd0, bus.bridge_en[0]};
    endcase
    return v;
  endfunction
  task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic expect_at(int due, int sel, logic [15:0] v, string tag);
    sb.push_back('{due, sel, v, tag});
  endtask
  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic drive(logic [3:0] m, logic [1:0] e);
    bus.motor_in = m;
    bus.motor_en = e;
  endtask
  task automatic pwm_count(output int h0, output int h1);
    h0 = 0;
    h1 = 0;
    repeat (256) begin
      @(negedge clk);
      h0 += int'(bus.bridge_en[0]);
      h1 += int'(bus.bridge_en[1]);
    end
  endtask
  always @(negedge clk)
    for (int i = sb.size() - 1; i >= 0; i--)
      if (sb[i].due == cyc) begin
        check(sb[i].tag, probe(sb[i].sel), sb[i].exp);
        sb.delete(i);
      end
  initial begin
    int c, h0, h1;
    bus.motor_in = 4'b0000;
    bus.motor_en = 2'b00;
    bus.duty_max = 8'd128;
    #1 check("reset_outputs", 16'({bus.bridge_in, bus.bridge_en, bus.busy}), 16'd0);
    step(3);
    rst_n = 1'b1;
    step(10);
    check("idle_after_reset", 16'({bus.bridge_in, bus.bridge_en, bus.busy}), 16'd0);
    c = cyc;
    drive(4'b1010, 2'b11);
    expect_at(c + 2, S_BIN, 16'h0, "start_edge2");
    expect_at(c + 3, S_BIN, 16'hA, "start_edge3");
    expect_at(c + 3, S_BUSY, 16'h0, "start_busy");
`ifdef MOTOR_DRV_RAMP_EN
    expect_at(c + 3, S_D0, 16'd0, "ramp_d0_0");
    expect_at(c + 7, S_D0, 16'd32, "ramp_d0_32");
    expect_at(c + 11, S_D0, 16'd64, "ramp_d0_64");
    expect_at(c + 15, S_D0, 16'd96, "ramp_d0_96");
    expect_at(c + 19, S_D0, 16'd128, "ramp_d0_128");
    expect_at(c + 19, S_D1, 16'd128, "ramp_d1_128");
`else
    expect_at(c + 3, S_D0, 16'd128, "start_d0_direct");
    expect_at(c + 3, S_D1, 16'd128, "start_d1_direct");
`endif
    step(30);
    pwm_count(h0, h1);
    check("run_pwm_high0", 16'(h0), 16'd128);
    check("run_pwm_high1", 16'(h1), 16'd128);
    c = cyc;
    drive(4'b1001, 2'b11);
    expect_at(c + 2, S_BIN, 16'hA, "rev_before");
    expect_at(c + 3, S_BIN, 16'h8, "rev_stop");
    expect_at(c + 3, S_BUSY, 16'h1, "rev_busy_first");
    expect_at(c + 3, S_D0, 16'd0, "rev_duty_zero");
    expect_at(c + 10, S_BEN0, 16'h0, "rev_en0_low");
    expect_at(c + 18, S_BUSY, 16'h1, "rev_busy_last");
    expect_at(c + 19, S_BUSY, 16'h0, "rev_busy_clear");
    expect_at(c + 19, S_BIN, 16'h8, "rev_gap_end");
    expect_at(c + 20, S_BIN, 16'h9, "rev_new_dir");
    expect_at(c + 20, S_D1, 16'd128, "rev_ch1_untouched");
`ifdef MOTOR_DRV_RAMP_EN
    expect_at(c + 24, S_D0, 16'd32, "rev_ramp_32");
    expect_at(c + 36, S_D0, 16'd128, "rev_ramp_128");
`else
    expect_at(c + 20, S_D0, 16'd128, "rev_duty_direct");
`endif
    step(45);
    c = cyc;
    drive(4'b1010, 2'b11);
    expect_at(c + 3, S_BIN, 16'h8, "dead_entry");
    expect_at(c + 3, S_BUSY, 16'h1, "dead_busy");
    expect_at(c + 14, S_BIN, 16'h8, "dead_ignores_cmd");
    expect_at(c + 18, S_BUSY, 16'h1, "dead_busy_end");
    expect_at(c + 20, S_BIN, 16'hA, "dead_final_cmd");
    step(5);
    drive(4'b1000, 2'b10);
    step(3);
    drive(4'b1001, 2'b11);
    step(2);
    drive(4'b1010, 2'b11);
    step(40);
    c = cyc;
    bus.duty_max = 8'd64;
    expect_at(c + 1, S_D0, 16'd64, "drop_d0");
    expect_at(c + 1, S_D1, 16'd64, "drop_d1");
    step(5);
    c = cyc;
    bus.duty_max = 8'd255;
`ifdef MOTOR_DRV_RAMP_EN
    expect_at(c + 1, S_D0, 16'd64, "raise_hold");
    expect_at(c + 5, S_D0, 16'd96, "raise_96");
    expect_at(c + 21, S_D0, 16'd224, "raise_224");
    expect_at(c + 25, S_D0, 16'd255, "raise_sat_d0");
    expect_at(c + 25, S_D1, 16'd255, "raise_sat_d1");
`else
    expect_at(c + 1, S_D0, 16'd255, "raise_d0_direct");
    expect_at(c + 1, S_D1, 16'd255, "raise_d1_direct");
`endif
    step(30);
    pwm_count(h0, h1);
    check("full_pwm_high0", 16'(h0), 16'd255);
    check("full_pwm_high1", 16'(h1), 16'd255);
    bus.duty_max = 8'd128;
    c = cyc;
    drive(4'b1110, 2'b11);
    expect_at(c + 3, S_BIN, 16'h2, "stop11_entry");
    expect_at(c + 3, S_BUSY, 16'h2, "stop11_busy");
    expect_at(c + 30, S_BIN, 16'h2, "stop11_stays_off");
    expect_at(c + 30, S_BUSY, 16'h0, "stop11_idle");
    step(35);
    #2 rst_n = 1'b0;
    #1 check("midrun_reset_outputs", 16'({bus.bridge_in, bus.bridge_en, bus.busy}), 16'd0);
    check("midrun_reset_duty", probe(S_D0), 16'd0);
    drive(4'b0000, 2'b00);
    step(3);
    rst_n = 1'b1;
    step(10);
    check("post_reset_quiet", 16'({bus.bridge_in, bus.bridge_en, bus.busy}), 16'd0);
    c = cyc;
    drive(4'b0110, 2'b11);
    expect_at(c + 3, S_BIN, 16'h6, "post_reset_start");
    step(25);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(7) == 0) drive(4'($urandom_range(15)), 2'($urandom_range(3)));
      step(1);
      check("no_shoot_through", 16'({bus.bridge_in[3:2] == 2'b11, bus.bridge_in[1:0] == 2'b11}), 16'd0);
    end
    for (int i = 0; i < 100 && sb.size() > 0; i++) step(1);
    check("scoreboard_drain", 16'(sb.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
